// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - periodic BCD converter poller and multiplexed 7-segment driver
// A committed image (digits, blank mask, valid) is swapped atomically so a scan slot never mixes old and new data.
module seven_seg_scanner #(
  parameter int DECIMAL_DIGITS = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SAMPLE_DIV     = 5000000,
  parameter int TIMEOUT        = 1024
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset_n,
  input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
  input  logic                        i_DV,
  output logic                        o_Start,
  output logic [6:0]                  o_Segments,
  output logic [DECIMAL_DIGITS-1:0]   o_Digit_En,
  output logic                        o_Error
);
  localparam int SAMPLE_W  = $clog2(SAMPLE_DIV + 1);
  localparam int REFRESH_W = $clog2(REFRESH_DIV + 1);
  localparam int TIMEOUT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W     = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
  localparam int BCD_W     = DECIMAL_DIGITS * 4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_LATCH} state_t;

  state_t                    r_state, w_state_next;
  logic [SAMPLE_W-1:0]       r_sample_cnt;
  logic [REFRESH_W-1:0]      r_refresh_cnt;
  logic [TIMEOUT_W-1:0]      r_timeout_cnt;
  logic [IDX_W-1:0]          r_index;
  logic                      r_load;
  logic [BCD_W-1:0]          r_display;
  logic [BCD_W-1:0]          r_shown;
  logic [DECIMAL_DIGITS-1:0] r_blank;
  logic [DECIMAL_DIGITS-1:0] w_blank_next;
  logic [DECIMAL_DIGITS-1:0] w_en_next;
  logic [DECIMAL_DIGITS-1:0] r_digit_en;
  logic                      r_valid;
  logic                      r_error;
  logic [6:0]                r_segments;
  logic [6:0]                w_seg_next;
  logic [3:0]                w_nibble;
  logic                      w_blank_sel;
  logic                      w_sample_tick;
  logic                      w_refresh_wrap;
  logic                      w_expire;
  logic                      w_capture;
  logic                      w_timeout;
  logic                      w_latch;
  logic                      w_start;

  function automatic logic [6:0] f_glyph(input logic [3:0] digit);
    case (digit)
      4'd0:    f_glyph = 7'h40;
      4'd1:    f_glyph = 7'h79;
      4'd2:    f_glyph = 7'h24;
      4'd3:    f_glyph = 7'h30;
      4'd4:    f_glyph = 7'h19;
      4'd5:    f_glyph = 7'h12;
      4'd6:    f_glyph = 7'h02;
      4'd7:    f_glyph = 7'h78;
      4'd8:    f_glyph = 7'h00;
      4'd9:    f_glyph = 7'h10;
      default: f_glyph = 7'h06;
    endcase
  endfunction

  assign w_sample_tick  = (r_sample_cnt == SAMPLE_W'(SAMPLE_DIV - 1));
  assign w_refresh_wrap = (r_refresh_cnt == REFRESH_W'(REFRESH_DIV - 1));
  assign w_expire       = (r_timeout_cnt == TIMEOUT_W'(TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_latch      = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE:  if (w_sample_tick) w_state_next = S_START;
      S_START: begin
        w_start      = 1'b1;
        w_state_next = S_WAIT;
      end
      // i_DV takes priority over an expiry in the same cycle
      S_WAIT: begin
        if (i_DV) begin
          w_capture    = 1'b1;
          w_state_next = S_LATCH;
        end else if (w_expire) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_LATCH: begin
        w_latch      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin : blank_mask
    logic w_seen;
    w_seen       = 1'b0;
    w_blank_next = '0;
    for (int n = DECIMAL_DIGITS - 1; n >= 1; n--) begin
      w_seen          = w_seen | (r_display[n*4 +: 4] != 4'd0);
      w_blank_next[n] = ~w_seen;
    end
  end

  always_comb begin
    w_nibble    = 4'd0;
    w_blank_sel = 1'b0;
    w_en_next   = '1;
    for (int n = 0; n < DECIMAL_DIGITS; n++) begin
      if (r_index == IDX_W'(n)) begin
        w_nibble     = r_shown[n*4 +: 4];
        w_blank_sel  = r_blank[n];
        w_en_next[n] = 1'b0;
      end
    end
    w_seg_next = (!r_valid || w_blank_sel) ? 7'h7F : f_glyph(w_nibble);
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_state       <= S_IDLE;
      r_sample_cnt  <= '0;
      r_refresh_cnt <= '0;
      r_timeout_cnt <= '0;
      r_index       <= '0;
      r_load        <= 1'b0;
      r_display     <= '0;
      r_shown       <= '0;
      r_blank       <= '0;
      r_valid       <= 1'b0;
      r_error       <= 1'b0;
      r_segments    <= 7'h7F;
      r_digit_en    <= ~DECIMAL_DIGITS'(1);
    end else begin
      r_state       <= w_state_next;
      r_sample_cnt  <= w_sample_tick ? '0 : r_sample_cnt + SAMPLE_W'(1);
      r_refresh_cnt <= w_refresh_wrap ? '0 : r_refresh_cnt + REFRESH_W'(1);
      r_timeout_cnt <= (r_state == S_WAIT) ? r_timeout_cnt + TIMEOUT_W'(1) : '0;
      // outputs follow the index one cycle after it moves, so a slot is never torn
      r_load        <= w_refresh_wrap;
      if (w_refresh_wrap) begin
        r_index <= (r_index == IDX_W'(DECIMAL_DIGITS - 1)) ? '0 : r_index + IDX_W'(1);
      end
      if (w_capture) r_display <= i_BCD;
      if (w_timeout) r_error <= 1'b1;
      if (w_latch) begin
        r_shown <= r_display;
        r_blank <= w_blank_next;
        r_valid <= 1'b1;
        r_error <= 1'b0;
      end
      if (r_load) begin
        r_segments <= w_seg_next;
        r_digit_en <= w_en_next;
      end
    end
  end

  assign o_Start    = w_start;
  assign o_Segments = r_segments;
  assign o_Digit_En = r_digit_en;
  assign o_Error    = r_error;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - randomized self-checking bench for seven_seg_scanner
// A time-based reference model predicts every output; directed literals pin the model.
module tb_seven_seg_scanner;
  localparam int D  = 4;
  localparam int RD = 4;
  localparam int SD = 64;
  localparam int TO = 32;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd   = 16'h0;
  logic        dv    = 1'b0;
  logic        o_start;
  logic [6:0]  seg;
  logic [3:0]  en;
  logic        err;

  seven_seg_scanner #(
    .DECIMAL_DIGITS(D),
    .REFRESH_DIV(RD),
    .SAMPLE_DIV(SD),
    .TIMEOUT(TO)
  ) dut (
    .i_Clock(clk),
    .i_Reset_n(rst_n),
    .i_BCD(bcd),
    .i_DV(dv),
    .o_Start(o_start),
    .o_Segments(seg),
    .o_Digit_En(en),
    .o_Error(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: m_t counts clock edges since reset release
  int          m_t         = 0;
  logic [15:0] m_shown     = 16'h0;
  logic [15:0] m_pend      = 16'h0;
  bit          m_valid     = 1'b0;
  bit          m_err       = 1'b0;
  bit          m_got       = 1'b0;
  int          m_commit_at = -1;
  bit          m_live      = 1'b0;
  logic        m_start     = 1'b0;
  logic [6:0]  m_seg       = 7'h7F;
  logic [3:0]  m_en        = 4'b1110;
  int          first_start = -1;
  int          first_err   = -1;
  logic [6:0]  sh [D];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h06;
    endcase
  endfunction

  function automatic logic [6:0] model_digit(input int idx);
    int hi = -1;
    if (!m_valid) return 7'h7F;
    for (int n = 0; n < D; n++) if (m_shown[n*4 +: 4] != 4'd0) hi = n;
    if (idx != 0 && idx > hi) return 7'h7F;
    return glyph(m_shown[idx*4 +: 4]);
  endfunction

  // Requests start at every multiple of SD edges; the wait window is offsets 1..TO.
  task automatic model_edge();
    int c;
    int w;
    int idx;
    if (!rst_n) begin
      m_t = 0; m_valid = 0; m_err = 0; m_got = 0; m_commit_at = -1;
      m_start = 0; m_seg = 7'h7F; m_en = 4'b1110;
      return;
    end
    c = m_t;
    m_t++;
    if (m_t > RD && (m_t - 1) % RD == 0) begin
      idx = ((m_t - 1) / RD) % D;
      m_en = 4'b1111;
      m_en[idx] = 1'b0;
      m_seg = model_digit(idx);
    end
    w = c % SD;
    if (c >= SD) begin
      if (w == 0) m_got = 0;
      else if (w <= TO && !m_got) begin
        if (dv) begin
          m_got = 1; m_pend = bcd; m_commit_at = m_t + 1;
        end else if (w == TO) m_err = 1;
      end
    end
    if (m_t == m_commit_at) begin
      m_shown = m_pend; m_valid = 1; m_err = 0; m_commit_at = -1;
    end
    m_start = (m_t >= SD) && (m_t % SD == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    m_live = 1'b1;
    #2;
    if (o_start && first_start < 0) first_start = m_t;
    if (err && first_err < 0) first_err = m_t;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (m_t < target && guard < 5000) begin
      step();
      guard++;
    end
    if (m_t < target) begin
      $display("FAIL run_to: reached %0d required %0d", m_t, target);
      n_checks++;
    end
  endtask

  task automatic pulse(input logic [15:0] v);
    bcd = v;
    dv  = 1'b1;
    step();
    dv  = 1'b0;
    bcd = 16'($urandom);
  endtask

  task automatic scan();
    for (int n = 0; n < D; n++) sh[n] = 7'h5A;
    for (int k = 0; k < 4 * RD + 4; k++) begin
      step();
      for (int n = 0; n < D; n++) if (en[n] === 1'b0) sh[n] = seg;
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      check("start", {31'b0, o_start}, {31'b0, m_start});
      check("segments", {25'b0, seg}, {25'b0, m_seg});
      check("digit_en", {28'b0, en}, {28'b0, m_en});
      check("error", {31'b0, err}, {31'b0, m_err});
    end
  end

  initial begin
    int base;
    int w;
    int lz;
    logic [15:0] v;
    repeat (3) step();
    check("reset_seg", {25'b0, seg}, 32'h7F);
    check("reset_en", {28'b0, en}, 32'hE);
    check("reset_start", {31'b0, o_start}, 32'h0);
    check("reset_error", {31'b0, err}, 32'h0);
    rst_n = 1'b1;

    run_to(100);
    check("first_start_cycle", first_start, 64);
    check("first_error_cycle", first_err, 97);
    check("blank_before_data", {25'b0, seg}, 32'h7F);

    run_to(133);
    pulse(16'h0042);
    run_to(168);
    scan();
    check("0042_d3", {25'b0, sh[3]}, 32'h7F);
    check("0042_d2", {25'b0, sh[2]}, 32'h7F);
    check("0042_d1", {25'b0, sh[1]}, 32'h19);
    check("0042_d0", {25'b0, sh[0]}, 32'h24);
    check("0042_error_cleared", {31'b0, err}, 32'h0);

    run_to(190);
    pulse(16'h1234);
    run_to(241);
    scan();
    check("idle_dv_ignored", {25'b0, sh[1]}, 32'h19);
    check("timeout_sticky", {31'b0, err}, 32'h1);

    run_to(288);
    pulse(16'h00A5);
    run_to(296);
    scan();
    check("00A5_d1", {25'b0, sh[1]}, 32'h06);
    check("00A5_d0", {25'b0, sh[0]}, 32'h12);
    check("00A5_d2", {25'b0, sh[2]}, 32'h7F);
    check("00A5_d3", {25'b0, sh[3]}, 32'h7F);
    check("expiry_dv_no_error", {31'b0, err}, 32'h0);

    run_to(330);
    pulse(16'h0000);
    run_to(340);
    scan();
    check("0000_d0", {25'b0, sh[0]}, 32'h40);
    check("0000_d1", {25'b0, sh[1]}, 32'h7F);
    check("0000_d3", {25'b0, sh[3]}, 32'h7F);

    run_to(390);
    pulse(16'h1000);
    run_to(400);
    scan();
    check("1000_d3", {25'b0, sh[3]}, 32'h79);
    check("1000_d2", {25'b0, sh[2]}, 32'h40);
    check("1000_d0", {25'b0, sh[0]}, 32'h40);

    run_to(452);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    first_start = -1;
    first_err   = -1;
    run_to(3);
    pulse(16'h9999);
    run_to(70);
    check("restart_start_cycle", first_start, 64);
    check("aborted_no_capture", {25'b0, seg}, 32'h7F);

    for (int k = 0; k < 20; k++) begin
      base = SD * (k + 2);
      lz = $urandom_range(0, 4);
      for (int n = 0; n < 4; n++) v[n*4 +: 4] = (n >= 4 - lz) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) w = $urandom_range(TO + 1, SD - 2);
      else w = $urandom_range(1, TO);
      if ($urandom_range(0, 4) == 0) begin
        run_to(base - 3);
        pulse(16'($urandom));
      end
      run_to(base + w);
      pulse(v);
      run_to(base + SD - 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
